// File: rtl/ray_march_stepper.sv
`default_nettype none
// ============================================================================
// Module   : ray_march_stepper
// Purpose  : Sphere-tracing controller that sits in front of the scene SDF
//            stage. For each accepted ray it issues p = o + t*d, waits the
//            SDF pipeline latency, advances t by the returned distance, and
//            stops on a hit, a far-plane miss or the step limit.
//            Number format: 27-bit float {sign, exp[7:0] bias 127, man[17:0]}.
// Ports    : clk, reset (async, active-high)
//            in_valid / in_ready, in_org_{x,y,z}, in_dir_{x,y,z}  - ray input
//            point_{x,y,z}                                       - to SDF
//            sdf_distance                                        - from SDF
//            out_valid / out_ready, out_hit, out_t, out_steps    - result
//            perf_rays, perf_steps (only with RAYMARCH_PERF_EN)  - counters
// Options  : `define RAYMARCH_PERF_EN adds saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module ray_march_stepper #(
    parameter int          SDF_LATENCY = 13,
    parameter int          MAX_STEPS   = 64,
    parameter logic [26:0] HIT_EPS     = 27'h1d40000,
    parameter logic [26:0] MAX_DIST    = 27'h2140000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in_org_x,
    input  logic [26:0] in_org_y,
    input  logic [26:0] in_org_z,
    input  logic [26:0] in_dir_x,
    input  logic [26:0] in_dir_y,
    input  logic [26:0] in_dir_z,
    output logic [26:0] point_x,
    output logic [26:0] point_y,
    output logic [26:0] point_z,
    input  logic [26:0] sdf_distance,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hit,
    output logic [26:0] out_t,
    output logic [6:0]  out_steps
`ifdef RAYMARCH_PERF_EN
    ,
    output logic [31:0] perf_rays,
    output logic [31:0] perf_steps
`endif
);

    localparam int                WAIT_W      = (SDF_LATENCY > 1) ? $clog2(SDF_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(SDF_LATENCY - 1);
    localparam logic [6:0]        C_MAX_STEPS = 7'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_ADD, S_WAIT, S_EVAL, S_CHECK, S_DONE
    } state_t;

    // Round-to-nearest-even and pack. mx = {hidden, man[17:0], guard, sticky}.
    // Exponent underflow flushes to signed zero, overflow saturates to max.
    function automatic logic [26:0] fround(input logic s, input logic signed [9:0] e,
                                           input logic [20:0] mx);
        logic              up;
        logic [19:0]       m;
        logic signed [9:0] er;
        up = mx[1] & (mx[0] | mx[2]);
        m  = {1'b0, mx[20:2]} + {19'd0, up};
        er = m[19] ? e + 10'sd1 : e;
        if (er <= 10'sd0)        return {s, 26'd0};
        else if (er >= 10'sd255) return {s, 8'hfe, 18'h3ffff};
        else                     return {s, er[7:0], (m[19] ? m[18:1] : m[17:0])};
    endfunction

    function automatic logic [26:0] fmul(input logic [26:0] a, input logic [26:0] b);
        logic [37:0]       p;
        logic signed [9:0] e;
        logic [20:0]       mx;
        p  = {19'd0, 1'b1, a[17:0]} * {19'd0, 1'b1, b[17:0]};
        e  = $signed({2'b00, a[25:18]}) + $signed({2'b00, b[25:18]}) - 10'sd127
           + (p[37] ? 10'sd1 : 10'sd0);
        mx = p[37] ? {p[37:18], |p[17:0]} : {p[36:17], |p[16:0]};
        if (a[25:18] == 8'd0 || b[25:18] == 8'd0) return {a[26] ^ b[26], 26'd0};
        return fround(a[26] ^ b[26], e, mx);
    endfunction

    function automatic logic [26:0] fadd(input logic [26:0] a, input logic [26:0] b);
        logic [26:0]       big;
        logic [26:0]       sml;
        logic [7:0]        d;
        logic [22:0]       mb;
        logic [22:0]       ms_full;
        logic [22:0]       ms;
        logic [22:0]       r;
        logic [21:0]       norm;
        logic [4:0]        sh;
        logic              st;
        logic signed [9:0] e;
        int                pos;
        if (a[25:18] == 8'd0) return b;
        if (b[25:18] == 8'd0) return a;
        if (a[25:0] >= b[25:0]) begin big = a; sml = b; end
        else                    begin big = b; sml = a; end
        d       = big[25:18] - sml[25:18];
        mb      = {2'b01, big[17:0], 3'b000};
        ms_full = {2'b01, sml[17:0], 3'b000};
        // Bits shifted out of the smaller operand collapse into a sticky lsb.
        if (d >= 8'd23) begin
            ms = 23'd0;
            st = 1'b1;
        end else begin
            ms = ms_full >> d;
            st = |(ms_full & ~(23'h7fffff << d));
        end
        ms[0] = ms[0] | st;
        r = (big[26] == sml[26]) ? (mb + ms) : (mb - ms);
        if (r == 23'd0) return 27'd0;
        e = $signed({2'b00, big[25:18]});
        if (r[22]) begin
            norm = {r[22:2], r[1] | r[0]};
            e    = e + 10'sd1;
        end else begin
            pos = 0;
            for (int i = 0; i < 22; i++) if (r[i]) pos = i;
            sh   = 5'(21 - pos);
            norm = r[21:0] << sh;
            e    = e - $signed({5'd0, sh});
        end
        return fround(big[26], e, {norm[21:2], |norm[1:0]});
    endfunction

    state_t            state_q;
    logic [26:0]       org_q   [3];
    logic [26:0]       dir_q   [3];
    logic [26:0]       prod_q  [3];
    logic [26:0]       point_q [3];
    logic [26:0]       t_q;
    logic [26:0]       dist_q;
    logic [6:0]        steps_q;
    logic [WAIT_W-1:0] wait_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_hit_q;
    logic [26:0]       out_t_q;
    logic [6:0]        out_steps_q;

    logic [26:0]       prod_d  [3];
    logic [26:0]       point_d [3];
    logic [26:0]       t_next_d;
    logic              hit_d;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            prod_d[k]  = fmul(t_q, dir_q[k]);
            point_d[k] = fadd(org_q[k], prod_q[k]);
        end
        t_next_d = fadd(t_q, dist_q);
        // Negative distances (including -0) mean the point is inside: a hit.
        hit_d    = dist_q[26] | (dist_q[25:0] < HIT_EPS[25:0]);
    end

`ifdef RAYMARCH_PERF_EN
    logic [31:0] perf_rays_q;
    logic [31:0] perf_steps_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int k = 0; k < 3; k++) begin
                org_q[k]   <= '0;
                dir_q[k]   <= '0;
                prod_q[k]  <= '0;
                point_q[k] <= '0;
            end
            t_q         <= '0;
            dist_q      <= '0;
            steps_q     <= '0;
            wait_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_t_q     <= '0;
            out_steps_q <= '0;
`ifdef RAYMARCH_PERF_EN
            perf_rays_q  <= '0;
            perf_steps_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        org_q      <= '{in_org_x, in_org_y, in_org_z};
                        dir_q      <= '{in_dir_x, in_dir_y, in_dir_z};
                        t_q        <= '0;
                        steps_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MUL;
`ifdef RAYMARCH_PERF_EN
                        if (perf_rays_q != 32'hffffffff) perf_rays_q <= perf_rays_q + 32'd1;
`endif
                    end
                end
                S_MUL: begin
                    prod_q  <= prod_d;
                    state_q <= S_ADD;
                end
                S_ADD: begin
                    point_q <= point_d;
                    wait_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == C_WAIT_LAST) begin
                        dist_q  <= sdf_distance;
                        state_q <= S_EVAL;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_EVAL: begin
                    steps_q <= steps_q + 7'd1;
`ifdef RAYMARCH_PERF_EN
                    if (perf_steps_q != 32'hffffffff) perf_steps_q <= perf_steps_q + 32'd1;
`endif
                    if (hit_d) begin
                        out_hit_q   <= 1'b1;
                        out_t_q     <= t_q;
                        out_steps_q <= steps_q + 7'd1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        t_q     <= t_next_d;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // t equal to the far plane keeps marching; only beyond it misses.
                    if ((t_q[25:0] > MAX_DIST[25:0]) || (steps_q == C_MAX_STEPS)) begin
                        out_hit_q   <= 1'b0;
                        out_t_q     <= t_q;
                        out_steps_q <= steps_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_MUL;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign point_x   = point_q[0];
    assign point_y   = point_q[1];
    assign point_z   = point_q[2];
    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_t     = out_t_q;
    assign out_steps = out_steps_q;
`ifdef RAYMARCH_PERF_EN
    assign perf_rays  = perf_rays_q;
    assign perf_steps = perf_steps_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_march_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_march_stepper
// Purpose  : Directed self-checking bench for ray_march_stepper. A behavioural
//            SDF (selectable distance function behind a point delay line)
//            feeds the stepper; results are compared with hand-computed values.
// Options  : RAYMARCH_PERF_EN also checks the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_march_stepper;

    localparam int          SDF_LATENCY = 13;
    localparam int          PIPE        = SDF_LATENCY - 1;
    localparam logic [26:0] F_0         = 27'h0000000;
    localparam logic [26:0] F_1         = 27'h1fc0000;
    localparam logic [26:0] F_2         = 27'h2000000;
    localparam logic [26:0] F_4         = 27'h2040000;
    localparam logic [26:0] F_10        = 27'h2090000;
    localparam logic [26:0] F_64        = 27'h2140000;
    localparam logic [26:0] F_70        = 27'h2146000;
    localparam logic [26:0] F_M0P5      = 27'h5f80000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] in_org_x = '0, in_org_y = '0, in_org_z = '0;
    logic [26:0] in_dir_x = '0, in_dir_y = '0, in_dir_z = '0;
    logic [26:0] point_x, point_y, point_z;
    logic [26:0] sdf_distance;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_hit;
    logic [26:0] out_t;
    logic [6:0]  out_steps;
`ifdef RAYMARCH_PERF_EN
    logic [31:0] perf_rays, perf_steps;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int sdf_mode = 0;

    always #5 clk = ~clk;

    ray_march_stepper #(.SDF_LATENCY(SDF_LATENCY)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_org_x(in_org_x), .in_org_y(in_org_y), .in_org_z(in_org_z),
        .in_dir_x(in_dir_x), .in_dir_y(in_dir_y), .in_dir_z(in_dir_z),
        .point_x(point_x), .point_y(point_y), .point_z(point_z),
        .sdf_distance(sdf_distance),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_t(out_t), .out_steps(out_steps)
`ifdef RAYMARCH_PERF_EN
        , .perf_rays(perf_rays), .perf_steps(perf_steps)
`endif
    );

    // ---------------- behavioural SDF ----------------
    function automatic real f2r(input logic [26:0] f);
        real v;
        int  e;
        if (f[25:18] == 8'd0) return 0.0;
        v = 1.0 + real'(f[17:0]) / 262144.0;
        e = int'(f[25:18]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[26] ? -v : v;
    endfunction

    function automatic logic [26:0] r2f(input real v_in);
        real         v;
        int          e;
        logic        s;
        logic [17:0] m;
        if (v_in == 0.0) return 27'd0;
        s = (v_in < 0.0);
        v = s ? -v_in : v_in;
        e = 127;
        while (v >= 2.0 && e < 254) begin v = v / 2.0; e++; end
        while (v < 1.0 && e > 1)    begin v = v * 2.0; e--; end
        m = 18'(int'((v - 1.0) * 262144.0));
        return {s, 8'(e), m};
    endfunction

    // Point delay line: sdf_distance reflects a new point by the last WAIT cycle.
    logic [26:0] pipe [PIPE];
    always @(posedge clk) begin
        pipe[0] <= point_z;
        for (int k = 1; k < PIPE; k++) pipe[k] <= pipe[k-1];
    end

    always_comb begin
        sdf_distance = F_0;
        case (sdf_mode)
            0: sdf_distance = r2f(4.0 - f2r(pipe[PIPE-1]));
            1: sdf_distance = F_10;
            2: sdf_distance = F_1;
            3: sdf_distance = F_M0P5;
            default: sdf_distance = F_0;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_ray(input logic [26:0] dz);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_org_x = F_0; in_org_y = F_0; in_org_z = F_0;
        in_dir_x = F_0; in_dir_y = F_0; in_dir_z = dz;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic take_result;
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("ready_after_take", {31'd0, in_ready}, 32'd1);
        check("valid_after_take", {31'd0, out_valid}, 32'd0);
    endtask

    logic [26:0] hold_t;
    logic [9:0]  hold_ctl;
    logic        seen_valid;

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_t", {5'd0, out_t}, 32'd0);
        check("rst_point_z", {5'd0, point_z}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef RAYMARCH_PERF_EN
        check("perf_rays_init", perf_rays, 32'd0);
`endif

        // ---- plane at z = 4: hit on step 2 ----
        sdf_mode = 0;
        send_ray(F_1);
        wait_done("plane", 33);
        check("plane_hit", {31'd0, out_hit}, 32'd1);
        check("plane_t", {5'd0, out_t}, {5'd0, F_4});
        check("plane_steps", {25'd0, out_steps}, 32'd2);
        take_result();

        // ---- constant 10: far-plane miss at t = 70 ----
        sdf_mode = 1;
        send_ray(F_1);
        wait_done("far", 7 * (SDF_LATENCY + 4));
        check("far_hit", {31'd0, out_hit}, 32'd0);
        check("far_t", {5'd0, out_t}, {5'd0, F_70});
        check("far_steps", {25'd0, out_steps}, 32'd7);

        // ---- backpressure: result held, second ray refused ----
        hold_t   = out_t;
        hold_ctl = {out_valid, in_ready, out_hit, out_steps};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = (c == 5);
            check("bp_t", {5'd0, out_t}, {5'd0, hold_t});
            check("bp_ctl", {22'd0, out_valid, in_ready, out_hit, out_steps},
                  {22'd0, 1'b1, 1'b0, 1'b0, 7'd7});
        end
        in_valid = 1'b0;
        take_result();
        seen_valid = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen_valid = 1'b1; end
        check("no_second_ray", {31'd0, seen_valid}, 32'd0);
        check("result_persists", {5'd0, out_t}, {5'd0, F_70});

        // ---- constant 1: step-limit miss with t exactly at far plane ----
        sdf_mode = 2;
        send_ray(F_1);
        wait_done("limit", 64 * (SDF_LATENCY + 4));
        check("limit_hit", {31'd0, out_hit}, 32'd0);
        check("limit_t", {5'd0, out_t}, {5'd0, F_64});
        check("limit_steps", {25'd0, out_steps}, 32'd64);
        take_result();

        // ---- negative distance on first sample ----
        sdf_mode = 3;
        send_ray(F_1);
        wait_done("inside", SDF_LATENCY + 3);
        check("inside_hit", {31'd0, out_hit}, 32'd1);
        check("inside_t", {5'd0, out_t}, 32'd0);
        check("inside_steps", {25'd0, out_steps}, 32'd1);
        take_result();

        // ---- reset during WAIT of step 3 ----
        sdf_mode = 2;
        send_ray(F_1);
        repeat (2 * (SDF_LATENCY + 4) + 6) @(posedge clk);
        #3;
        check("mid_point_z", {5'd0, point_z}, {5'd0, F_2});
`ifdef RAYMARCH_PERF_EN
        check("perf_rays_pre", perf_rays, 32'd5);
        check("perf_steps_pre", perf_steps, 32'd76);
`endif
        reset = 1'b1;
        #1;
        check("abort_point_z", {5'd0, point_z}, 32'd0);
        check("abort_out", {4'd0, out_hit, out_t}, 32'd0);
        check("abort_steps", {25'd0, out_steps}, 32'd0);
        check("abort_ready", {30'd0, in_ready, out_valid}, 32'd0);
`ifdef RAYMARCH_PERF_EN
        check("perf_rays_clr", perf_rays, 32'd0);
        check("perf_steps_clr", perf_steps, 32'd0);
`endif
        @(posedge clk);
        #3 reset = 1'b0;
        seen_valid = 1'b0;
        repeat (100) begin @(negedge clk); if (out_valid) seen_valid = 1'b1; end
        check("abort_no_result", {31'd0, seen_valid}, 32'd0);

        // ---- fresh ray after abort ----
        sdf_mode = 0;
        send_ray(F_1);
        wait_done("fresh", 33);
        check("fresh_hit", {31'd0, out_hit}, 32'd1);
        check("fresh_t", {5'd0, out_t}, {5'd0, F_4});
        check("fresh_steps", {25'd0, out_steps}, 32'd2);
`ifdef RAYMARCH_PERF_EN
        check("perf_rays_post", perf_rays, 32'd1);
        check("perf_steps_post", perf_steps, 32'd2);
`endif
        take_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
